stream_mux_arb: RTL and testbench

- Parametrised N-channel, W-bit successor to the 4:1 selector.
- Adds valid/ready handshakes, a registered output stage, and packet locking.
- Two selection modes: fixed (external select) or round-robin arbitration.
- Sits between multiple requesters (e.g. fetch/load/DMA streams) and a single shared consumer such as a memory port.

---
 rtl/stream_mux_arb_pkg.sv | 10 +
 rtl/stream_mux_arb_rr_pick.sv | 34 +++
 rtl/stream_mux_arb.sv | 109 ++++++++++
 tb/tb_stream_mux_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_arb_pkg.sv
// Shared constants for the stream multiplexer/arbiter and its helpers.
package stream_mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/stream_mux_arb_rr_pick.sv
// Round-robin picker: returns the first requester strictly after ptr,
// wrapping from the top channel back to channel 0.
module stream_mux_arb_rr_pick #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    idx,
    output logic                found
);

    int bestDist;

    // Distance 0 is the channel right after ptr; ptr itself is farthest.
    function automatic int distFrom(input int chan, input logic [SEL_W-1:0] p);
        return (chan - int'(p) - 1 + 2 * CHANNELS) % CHANNELS;
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        bestDist = CHANNELS;
        for (int j = 0; j < CHANNELS; j++) begin
            if (req[j] && (distFrom(j, ptr) < bestDist)) begin
                bestDist = distFrom(j, ptr);
                idx      = SEL_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with fixed or round-robin selection,
// packet locking and a single registered output stage.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [0:0]       state;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rrPtr;

    logic [SEL_W-1:0] rrIdx;
    logic             rrFound;
    logic             fixedHit;
    logic [SEL_W-1:0] candIdx;
    logic             candFound;

    logic             grantValid;
    logic             grantLast;
    logic [WIDTH-1:0] grantData;
    logic             slotFree;
    logic             accept;

    stream_mux_arb_rr_pick #(
        .CHANNELS(CHANNELS)
    ) rrPick (
        .req  (in_valid),
        .ptr  (rrPtr),
        .idx  (rrIdx),
        .found(rrFound)
    );

    // Out-of-range sel values match no channel, so fixed mode just keeps waiting.
    always_comb begin
        fixedHit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == sel) fixedHit = in_valid[i];
        end
        if (mode == MODE_RR) begin
            candIdx   = rrIdx;
            candFound = rrFound;
        end else begin
            candIdx   = sel;
            candFound = fixedHit;
        end
    end

    assign grantValid = in_valid[grant];
    assign grantLast  = in_last[grant];
    assign grantData  = in_data[grant*WIDTH +: WIDTH];
    assign slotFree   = !out_valid || out_ready;
    assign accept     = (state == ST_BUSY) && grantValid && slotFree;

    always_comb begin
        in_ready = '0;
        if (state == ST_BUSY) in_ready[grant] = slotFree;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rrPtr     <= SEL_W'(CHANNELS - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (candFound) begin
                    grant <= candIdx;
                    state <= ST_BUSY;
                end
            end else if (accept && grantLast) begin
                state <= ST_IDLE;
                rrPtr <= grant;
            end

            // A same-cycle drain and accept reloads the register without a bubble.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grantData;
                out_last  <= grantLast;
                out_chan  <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: randomized sources, a packet-level
// round-robin model, and a monitor that checks every output beat and in_ready.
module tb_stream_mux_arb;

    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int SEL_W = 2;

    typedef struct {
        int               chan;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        logic [WIDTH-1:0] base;
        int               len;
    } pkt_t;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [CH*WIDTH-1:0]    in_data;
    logic [CH-1:0]          in_valid;
    logic [CH-1:0]          in_last;
    logic [CH-1:0]          in_ready;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic [SEL_W-1:0]       out_chan;
    logic                   out_valid;
    logic                   out_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t         srcQ[CH][$];
    pkt_t          pend[CH][$];
    beat_t         expQ[$];
    int            acceptQ[$];
    int            fireCyc[$];
    logic [CH-1:0] midPkt;
    int            gapPct = 0;
    bit            readyRand = 0;
    int            stallLeft = 0;
    int            lastChan = CH - 1;

    logic             prevStall;
    logic [WIDTH-1:0] prevData;
    logic             prevLast;
    logic [SEL_W-1:0] prevChan;

    stream_mux_arb #(
        .WIDTH(WIDTH),
        .CHANNELS(CH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_last (out_last),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic srcPacket(input int ch, input logic [WIDTH-1:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.chan = ch;
            b.data = base + WIDTH'(k);
            b.last = (k == len - 1);
            srcQ[ch].push_back(b);
        end
    endtask

    task automatic expPacket(input int ch, input logic [WIDTH-1:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.chan = ch;
            b.data = base + WIDTH'(k);
            b.last = (k == len - 1);
            expQ.push_back(b);
            acceptQ.push_back(ch);
        end
        lastChan = ch;
    endtask

    // Every pending channel presents its next first beat at once, so packets
    // are served strictly in rotation after the last channel that completed.
    task automatic rrSchedule();
        bit   any;
        int   c;
        int   k;
        pkt_t p;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            k   = 1;
            c   = 0;
            while (!any && k <= CH) begin
                c = (lastChan + k) % CH;
                if (pend[c].size() != 0) any = 1'b1;
                else k++;
            end
            if (any) begin
                p = pend[c].pop_front();
                srcPacket(c, p.base, p.len);
                expPacket(c, p.base, p.len);
            end
        end
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, expQ.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Source driver and consumer-ready generator.
    initial begin : driver
        logic [CH-1:0] hs;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        midPkt    = '0;
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < CH; i++) begin
                if (hs[i] && srcQ[i].size() != 0) begin
                    midPkt[i] = !srcQ[i][0].last;
                    void'(srcQ[i].pop_front());
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (srcQ[i].size() != 0 && !(midPkt[i] && $urandom_range(99) < gapPct)) begin
                    in_valid[i]                 = 1'b1;
                    in_last[i]                  = srcQ[i][0].last;
                    in_data[i*WIDTH +: WIDTH]   = srcQ[i][0].data;
                end else begin
                    in_valid[i]                 = 1'b0;
                    in_last[i]                  = 1'b0;
                    in_data[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
                end
            end
            if (!readyRand) begin
                out_ready = 1'b1;
            end else if (stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else if ($urandom_range(9) == 0) begin
                out_ready = 1'b0;
                stallLeft = 3;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
        end
    end

    // Monitor: output beats against the scoreboard, hold stability, in_ready legality.
    initial begin : monitor
        logic [CH-1:0] allowed;
        beat_t         e;
        prevStall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(prevData));
                    check("hold_last", 32'(out_last), 32'(prevLast));
                    check("hold_chan", 32'(out_chan), 32'(prevChan));
                end
                allowed = '0;
                if (acceptQ.size() != 0) allowed[acceptQ[0]] = 1'b1;
                check("ready_other_chan", 32'(in_ready & ~allowed), 32'd0);
                if (out_valid && !out_ready) check("ready_in_stall", 32'(in_ready), 32'd0);
                if ((in_valid & in_ready) != '0 && acceptQ.size() != 0) void'(acceptQ.pop_front());
                if (out_valid && out_ready) begin
                    fireCyc.push_back(cyc);
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got chan %0d data 0x%0h, expected no beat",
                                 out_chan, out_data);
                    end else begin
                        e = expQ.pop_front();
                        check("out_chan", 32'(out_chan), 32'(e.chan));
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                prevLast  = out_last;
                prevChan  = out_chan;
            end
        end
    end

    initial begin : stimulus
        pkt_t p;
        int   rel;
        int   ld;
        int   n;

        rstn = 1'b0;
        mode = 1'b1;
        sel  = '0;

        // Reset with all channels active, then RR over single-beat packets.
        p.len = 1;
        p.base = 16'h0010; pend[0].push_back(p);
        p.base = 16'h0050; pend[0].push_back(p);
        p.base = 16'h0020; pend[1].push_back(p);
        p.base = 16'h0030; pend[2].push_back(p);
        p.base = 16'h0040; pend[3].push_back(p);
        lastChan = CH - 1;
        rrSchedule();
        repeat (4) @(negedge clk);
        check("rst_in_valid_active", 32'(in_valid), 32'hF);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        @(negedge clk);
        #1 rstn = 1'b1;
        rel = cyc;
        fireCyc.delete();
        waitDrain(200, "rr_single_drain");
        check("rr_fire_count", 32'(fireCyc.size()), 32'd5);
        if (fireCyc.size() == 5) begin
            check("rr_first_latency", 32'(fireCyc[0] - rel), 32'd2);
            for (int k = 1; k < 5; k++) check("rr_gap", 32'(fireCyc[k] - fireCyc[k-1]), 32'd2);
        end

        // Fixed mode on ch2 while ch0 also has a packet waiting.
        mode = 1'b0;
        sel  = 2'd2;
        @(posedge clk);
        #2;
        ld = cyc;
        fireCyc.delete();
        srcPacket(2, 16'h00A1, 3);
        srcPacket(0, 16'h00B1, 2);
        expPacket(2, 16'h00A1, 3);
        waitDrain(200, "fixed_drain");
        repeat (10) @(negedge clk);
        check("fixed_fire_count", 32'(fireCyc.size()), 32'd3);
        if (fireCyc.size() == 3) begin
            for (int k = 0; k < 3; k++) check("fixed_beat_cycle", 32'(fireCyc[k] - ld), 32'(3 + k));
        end
        check("fixed_ch0_untouched", 32'(srcQ[0].size()), 32'd2);
        check("fixed_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        expPacket(0, 16'h00B1, 2);
        sel = 2'd0;
        waitDrain(200, "fixed_sel0_drain");

        // Randomized RR with in-packet valid gaps and consumer backpressure.
        mode      = 1'b1;
        gapPct    = 30;
        readyRand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            #2;
            for (int c = 0; c < CH; c++) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    p.base = WIDTH'($urandom);
                    p.len  = $urandom_range(1, 5);
                    pend[c].push_back(p);
                end
            end
            rrSchedule();
            waitDrain(3000, "random_drain");
        end

        // Reset in the middle of a 4-beat packet; RR restarts from ch0.
        gapPct    = 0;
        readyRand = 1'b0;
        @(posedge clk);
        #2;
        p.len = 1; p.base = 16'h000E; pend[0].push_back(p);
        rrSchedule();
        waitDrain(200, "pre_reset_drain");
        @(posedge clk);
        #2;
        p.len = 4; p.base = 16'h00C1; pend[1].push_back(p);
        rrSchedule();
        n = 0;
        while (expQ.size() > 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midpkt_reached_beat2", 32'(expQ.size() <= 3), 32'd1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midpkt_rst_out_valid", 32'(out_valid), 32'd0);
        check("midpkt_rst_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < CH; c++) srcQ[c].delete();
        expQ.delete();
        acceptQ.delete();
        midPkt   = '0;
        in_valid = '0;
        lastChan = CH - 1;
        p.len = 1;
        p.base = 16'h0061; pend[3].push_back(p);
        p.base = 16'h0062; pend[1].push_back(p);
        p.base = 16'h0063; pend[2].push_back(p);
        p.base = 16'h0064; pend[0].push_back(p);
        rrSchedule();
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        waitDrain(200, "post_reset_drain");

        for (int c = 0; c < CH; c++) check("src_empty", 32'(srcQ[c].size()), 32'd0);
        check("accept_queue_empty", 32'(acceptQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
